// File: rtl/apb_sram_pkg.sv
// apb_sram_pkg: shared types and constants for the APB to SRAM bridge
package apb_sram_pkg;
  localparam int SRAM_DW = 32;
  localparam int STRB_W = SRAM_DW / 8;
  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} bridge_state_e;
  typedef enum logic [1:0] {ERR_NONE, ERR_DECODE, ERR_PARITY, ERR_TIMEOUT} err_cause_e;
endpackage

// File: rtl/apb_sram_bridge.sv
// apb_sram_bridge: APB completer issuing one SRAM req/gnt/rvalid transaction per transfer, flagging decode, parity and grant-timeout faults on pslverr_o
module apb_sram_bridge
  import apb_sram_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_WORDS = 1024,
  parameter int APB_AW = 32,
  parameter logic [APB_AW-1:0] BASE_ADDR = '0,
  parameter int GNT_TIMEOUT = 16,
  localparam int MEM_AW = $clog2(NUM_WORDS)
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  psel_i,
  input  logic                  penable_i,
  input  logic                  pwrite_i,
  input  logic [APB_AW-1:0]     paddr_i,
  input  logic [DATA_WIDTH-1:0] pwdata_i,
  input  logic [STRB_W-1:0]     pstrb_i,
  output logic [DATA_WIDTH-1:0] prdata_o,
  output logic                  pready_o,
  output logic                  pslverr_o,
  output logic                  mem_req_o,
  output logic                  mem_we_o,
  output logic                  mem_rready_o,
  output logic [MEM_AW-1:0]     mem_addr_o,
  output logic [DATA_WIDTH-1:0] mem_wdata_o,
  output logic [STRB_W-1:0]     mem_be_o,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i,
  input  logic                  mem_rvalid_i,
  input  logic                  mem_rvalidpar_i,
  input  logic                  mem_gnt_i,
  input  logic                  mem_gntpar_i
);
  bridge_state_e state_q, state_d;
  err_cause_e cause_q, cause_d;
  logic [7:0] cnt_q, cnt_d;
  logic [MEM_AW-1:0] addr_q;
  logic we_q;
  logic [DATA_WIDTH-1:0] wdata_q, prdata_d;
  logic [STRB_W-1:0] be_q;
  logic [APB_AW-1:0] off;
  logic setup, dec_err, par_err, gnt_ok, rv_ok;
  assign setup = psel_i & ~penable_i;
  assign off = paddr_i - BASE_ADDR;
  assign dec_err = (off >= APB_AW'(NUM_WORDS)) | (|paddr_i[1:0]);
  assign par_err = (mem_gnt_i == mem_gntpar_i) | (mem_rvalid_i == mem_rvalidpar_i);
  assign gnt_ok = mem_gnt_i & ~mem_gntpar_i;
  assign rv_ok = mem_rvalid_i & ~mem_rvalidpar_i;
  always_comb begin
    state_d = state_q;
    cause_d = cause_q;
    cnt_d = cnt_q;
    prdata_d = prdata_o;
    unique case (state_q)
      IDLE: if (setup) begin
        state_d = dec_err ? RESP : REQ;
        cause_d = dec_err ? ERR_DECODE : ERR_NONE;
      end
      REQ: begin
        cnt_d = cnt_q + 8'd1;
        if (par_err) begin
          state_d = RESP;
          cause_d = ERR_PARITY;
        end else if (gnt_ok) begin
          state_d = WAIT;
        end else if (cnt_d == 8'(GNT_TIMEOUT)) begin
          state_d = RESP;
          cause_d = ERR_TIMEOUT;
        end
      end
      WAIT: if (par_err) begin
        state_d = RESP;
        cause_d = ERR_PARITY;
      end else if (rv_ok) begin
        state_d = RESP;
        prdata_d = we_q ? '0 : mem_rdata_i;
      end
      RESP: begin
        state_d = IDLE;
        cause_d = ERR_NONE;
        cnt_d = '0;
        prdata_d = '0;
      end
    endcase
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      cause_q <= ERR_NONE;
      cnt_q <= '0;
      prdata_o <= '0;
      addr_q <= '0;
      we_q <= 1'b0;
      wdata_q <= '0;
      be_q <= '0;
    end else begin
      state_q <= state_d;
      cause_q <= cause_d;
      cnt_q <= cnt_d;
      prdata_o <= prdata_d;
      if (state_q == IDLE && setup) begin
        addr_q <= off[MEM_AW-1:0];
        we_q <= pwrite_i;
        wdata_q <= pwdata_i;
        be_q <= pwrite_i ? pstrb_i : '1;
      end
    end
  end
  assign mem_req_o = state_q == REQ;
  assign mem_rready_o = state_q == WAIT;
  assign mem_we_o = mem_req_o & we_q;
  assign mem_addr_o = addr_q;
  assign mem_wdata_o = wdata_q;
  assign mem_be_o = be_q;
  assign pready_o = state_q == RESP;
  assign pslverr_o = pready_o & (cause_q != ERR_NONE);
endmodule

// File: tb/tb_apb_sram_bridge.sv
// tb_apb_sram_bridge: directed APB transfers against an SRAM responder with a transfer-level reference model
module tb_apb_sram_bridge;
  localparam int TMO = 16;
  logic clk_i = 1'b0;
  logic rst_ni, psel_i, penable_i, pwrite_i;
  logic [31:0] paddr_i, pwdata_i, prdata_o, mem_wdata_o, mem_rdata_i;
  logic [3:0] pstrb_i, mem_be_o;
  logic pready_o, pslverr_o, mem_req_o, mem_we_o, mem_rready_o;
  logic [9:0] mem_addr_o;
  logic mem_rvalid_i, mem_rvalidpar_i, mem_gnt_i, mem_gntpar_i;
  int checks = 0, errors = 0;
  logic [31:0] sram [256];
  logic [31:0] model [256];
  bit active = 0, done = 0, manual = 0;
  bit gnt_en = 1, gnt_fault = 0, rv_fault = 0;
  int cyc, req_seen, exp_lat, exp_req;
  logic exp_err, exp_we, pend;
  logic [31:0] exp_rdata, exp_wdata, last_rdata, rd_next;
  logic [9:0] exp_addr;
  logic [3:0] exp_be;
  always #5 clk_i = ~clk_i;
  apb_sram_bridge dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .psel_i(psel_i), .penable_i(penable_i),
    .pwrite_i(pwrite_i), .paddr_i(paddr_i), .pwdata_i(pwdata_i), .pstrb_i(pstrb_i),
    .prdata_o(prdata_o), .pready_o(pready_o), .pslverr_o(pslverr_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_rready_o(mem_rready_o),
    .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o), .mem_be_o(mem_be_o),
    .mem_rdata_i(mem_rdata_i), .mem_rvalid_i(mem_rvalid_i), .mem_rvalidpar_i(mem_rvalidpar_i),
    .mem_gnt_i(mem_gnt_i), .mem_gntpar_i(mem_gntpar_i)
  );
  assign mem_gnt_i = gnt_en & mem_req_o;
  assign mem_gntpar_i = gnt_fault ? 1'b0 : ~mem_gnt_i;
  assign mem_rvalidpar_i = rv_fault ? 1'b1 : ~mem_rvalid_i;
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", n, act, exp, $time);
    end
  endtask
  initial begin
    mem_rvalid_i = 0;
    mem_rdata_i = '0;
    pend = 0;
    rd_next = '0;
    forever begin
      @(negedge clk_i);
      if (!rst_ni) begin
        pend = 0;
        mem_rvalid_i = 0;
        mem_rdata_i = '0;
      end else begin
        mem_rvalid_i = pend;
        mem_rdata_i = pend ? rd_next : '0;
        pend = 0;
        if (mem_req_o && mem_gnt_i) begin
          for (int b = 0; b < 4; b++)
            if (mem_we_o && mem_be_o[b]) sram[mem_addr_o[9:2]][8*b+:8] = mem_wdata_o[8*b+:8];
          rd_next = sram[mem_addr_o[9:2]];
          pend = 1;
        end
      end
    end
  end
  always @(negedge clk_i) begin
    if (!manual) begin
      if (active) begin
        cyc++;
        if (mem_req_o) begin
          req_seen++;
          chk("mem_we", 32'(mem_we_o), 32'(exp_we));
          chk("mem_addr", 32'(mem_addr_o), 32'(exp_addr));
          chk("mem_be", 32'(mem_be_o), 32'(exp_be));
          if (exp_we) chk("mem_wdata", mem_wdata_o, exp_wdata);
        end
        if (pready_o) begin
          chk("latency", cyc, exp_lat);
          chk("pslverr", 32'(pslverr_o), 32'(exp_err));
          chk("prdata", prdata_o, exp_rdata);
          chk("req_cycles", req_seen, exp_req);
          last_rdata = prdata_o;
          active = 0;
          done = 1;
        end
      end else begin
        chk("idle_outputs", {27'd0, pready_o, pslverr_o, mem_req_o, mem_rready_o, |prdata_o}, 32'd0);
      end
    end
  end
  task automatic xfer(input bit wr, input logic [31:0] addr, input logic [31:0] data,
                      input logic [3:0] strb, input int gm, input bit rvf, input bit drop,
                      input bit use_lit, input logic [31:0] lit);
    logic [31:0] off;
    bit dec;
    off = addr;
    dec = (off >= 32'd1024) || (addr[1:0] != 2'b00);
    exp_we = wr;
    exp_addr = off[9:0];
    exp_be = wr ? strb : 4'hF;
    exp_wdata = data;
    exp_rdata = '0;
    exp_err = 0;
    if (dec) begin
      exp_err = 1; exp_lat = 2; exp_req = 0;
    end else if (gm == 1) begin
      exp_err = 1; exp_lat = TMO + 2; exp_req = TMO;
    end else if (gm == 2) begin
      exp_err = 1; exp_lat = 3; exp_req = 1;
    end else begin
      exp_lat = 4; exp_req = 1;
      if (wr) begin
        for (int b = 0; b < 4; b++) if (strb[b]) model[off[9:2]][8*b+:8] = data[8*b+:8];
      end else if (rvf) exp_err = 1;
      else exp_rdata = model[off[9:2]];
    end
    if (use_lit) chk("model_literal", exp_rdata, lit);
    gnt_en = (gm == 0);
    gnt_fault = (gm == 2);
    rv_fault = rvf;
    done = 0; cyc = 0; req_seen = 0; active = 1;
    psel_i = 1; penable_i = 0; pwrite_i = wr; paddr_i = addr; pwdata_i = data; pstrb_i = strb;
    @(posedge clk_i); #1;
    if (drop) psel_i = 0; else penable_i = 1;
    for (int i = 0; i < 40 && !done; i++) begin
      @(posedge clk_i); #1;
    end
    if (!done) begin
      checks++; errors++;
      $display("FAIL pready_timeout: no pready for addr %h after 40 cycles", addr);
      active = 0;
    end
    if (use_lit) chk("rdata_literal", last_rdata, lit);
    psel_i = 0; penable_i = 0;
    gnt_en = 1; gnt_fault = 0; rv_fault = 0;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    for (int i = 0; i < 256; i++) begin
      sram[i] = '0;
      model[i] = '0;
    end
    rst_ni = 0; psel_i = 0; penable_i = 0; pwrite_i = 0; paddr_i = '0; pwdata_i = '0; pstrb_i = '0;
    repeat (3) @(posedge clk_i);
    #1;
    chk("reset_outputs", {23'd0, pready_o, pslverr_o, mem_req_o, mem_rready_o, mem_we_o,
        |prdata_o, |mem_addr_o, |mem_be_o, |mem_wdata_o}, 32'd0);
    rst_ni = 1;
    @(posedge clk_i); #1;
    xfer(1, 32'h10, 32'hDEADBEEF, 4'hF, 0, 0, 0, 0, '0);
    xfer(0, 32'h10, '0, 4'h0, 0, 0, 0, 1, 32'hDEADBEEF);
    xfer(1, 32'h20, 32'h11223344, 4'hF, 0, 0, 0, 0, '0);
    xfer(1, 32'h20, 32'h0000AA00, 4'b0010, 0, 0, 0, 0, '0);
    xfer(0, 32'h20, '0, 4'h0, 0, 0, 0, 1, 32'h1122AA44);
    xfer(1, 32'h20, 32'hFFFFFFFF, 4'h0, 0, 0, 0, 0, '0);
    xfer(0, 32'h20, '0, 4'h0, 0, 0, 0, 1, 32'h1122AA44);
    xfer(0, 32'h400, '0, 4'h0, 0, 0, 0, 0, '0);
    xfer(0, 32'h13, '0, 4'h0, 0, 0, 0, 0, '0);
    xfer(1, 32'h400, 32'h12345678, 4'hF, 0, 0, 0, 0, '0);
    xfer(0, 32'h10, '0, 4'h0, 1, 0, 0, 0, '0);
    xfer(0, 32'h10, '0, 4'h0, 0, 1, 0, 1, 32'h0);
    xfer(0, 32'h10, '0, 4'h0, 2, 0, 0, 0, '0);
    xfer(0, 32'h10, '0, 4'h0, 0, 0, 1, 1, 32'hDEADBEEF);
    xfer(1, 32'h3FC, 32'hCAFEF00D, 4'hF, 0, 0, 0, 0, '0);
    xfer(0, 32'h3FC, '0, 4'h0, 0, 0, 0, 1, 32'hCAFEF00D);
    repeat (2) @(posedge clk_i);
    #1;
    manual = 1;
    psel_i = 1; penable_i = 0; pwrite_i = 0; paddr_i = 32'h10; pstrb_i = 4'h0;
    @(posedge clk_i); #1;
    penable_i = 1;
    @(posedge clk_i); #1;
    chk("wait_rready", 32'(mem_rready_o), 32'd1);
    rst_ni = 0;
    #1;
    chk("async_reset_ctrl", {27'd0, mem_req_o, mem_rready_o, pready_o, pslverr_o, mem_we_o}, 32'd0);
    chk("async_reset_data", {29'd0, |prdata_o, |mem_addr_o, |mem_be_o}, 32'd0);
    psel_i = 0; penable_i = 0;
    @(negedge clk_i);
    @(posedge clk_i); #1;
    rst_ni = 1;
    @(posedge clk_i); #1;
    manual = 0;
    @(posedge clk_i); #1;
    xfer(0, 32'h10, '0, 4'h0, 0, 0, 0, 1, 32'hDEADBEEF);
    repeat (2) @(posedge clk_i);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
